// File: rtl/hc148_irq_latch.sv
// hc148_irq_latch: request front-end of the interrupt path behind an hc148
// 8-to-3 priority encoder. It drives the encoder enable, synchronises the
// encoder outputs, and qualifies a request as stable before it latches the
// vector. It then holds a level interrupt until the request is acknowledged.
//
// Optional feature macro: HC148_IRQ_CNT_EN. When it is defined, the block
// adds eight saturating per-vector service counters. When it is undefined,
// cnt_o is tied to zero. The port list is the same in both builds.
module hc148_irq_latch #(
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_N,
    input  logic             en,
    input  logic [2:0]       out_N,
    input  logic             GS_N,
    input  logic             EO_N,
    output logic             EI_N,
    output logic             irq_o,
    output logic [2:0]       vec_o,
    input  logic             ack_i,
    output logic             idle_o,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int QW = $clog2(STABLE_CYCLES + 1);
    localparam logic [QW:0] QUAL_LAST = (QW+1)'(STABLE_CYCLES);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] QUAL     = 2'd1;
    localparam logic [1:0] PEND     = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    logic [2:0]    outNMeta_q, outN_s;
    logic          gsNMeta_q, gsN_s;
    logic          eoNMeta_q, eoN_s;
    logic          eiN_q;
    logic [1:0]    state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [QW:0]   qcntInc;
    logic [2:0]    cand_q, cand_d;
    logic [2:0]    vec_q, vec_d;
    logic          irq_q, irq_d;
    logic [2:0]    reqVec;

    // Two-flop synchroniser. The flops come out of reset at the encoder's
    // inactive levels, so nothing looks like a request while reset is active.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            outNMeta_q <= 3'b111;
            outN_s     <= 3'b111;
            gsNMeta_q  <= 1'b1;
            gsN_s      <= 1'b1;
            eoNMeta_q  <= 1'b1;
            eoN_s      <= 1'b1;
        end else begin
            outNMeta_q <= out_N;
            outN_s     <= outNMeta_q;
            gsNMeta_q  <= GS_N;
            gsN_s      <= gsNMeta_q;
            eoNMeta_q  <= EO_N;
            eoN_s      <= eoNMeta_q;
        end
    end

    assign reqVec  = ~outN_s;
    assign qcntInc = {1'b0, qcnt_q} + {{QW{1'b0}}, 1'b1};

    // Next-state logic for the request FSM. The cycle spent in IDLE counts
    // as the first stable cycle, so QUAL leaves once the cycle it is
    // evaluating brings the count up to STABLE_CYCLES.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        cand_d  = cand_q;
        vec_d   = vec_q;
        irq_d   = irq_q;
        if (!en) begin
            state_d = IDLE;
            qcnt_d  = '0;
            irq_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!gsN_s) begin
                        state_d = QUAL;
                        qcnt_d  = {{(QW-1){1'b0}}, 1'b1};
                        cand_d  = reqVec;
                    end
                end
                QUAL: begin
                    if (gsN_s) begin
                        state_d = IDLE;
                        qcnt_d  = '0;
                    end else if (reqVec != cand_q) begin
                        qcnt_d  = {{(QW-1){1'b0}}, 1'b1};
                        cand_d  = reqVec;
                    end else if (qcntInc >= QUAL_LAST) begin
                        state_d = PEND;
                        qcnt_d  = '0;
                        vec_d   = cand_q;
                        irq_d   = 1'b1;
                    end else begin
                        qcnt_d  = qcntInc[QW-1:0];
                    end
                end
                PEND: begin
                    if (ack_i) begin
                        state_d = WAIT_REL;
                        irq_d   = 1'b0;
                    end
                end
                default: begin
                    if (gsN_s || (reqVec != vec_q)) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // FSM state, the latched vector, the interrupt, and the registered encoder enable.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_q <= IDLE;
            qcnt_q  <= '0;
            cand_q  <= 3'd0;
            vec_q   <= 3'd0;
            irq_q   <= 1'b0;
            eiN_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            cand_q  <= cand_d;
            vec_q   <= vec_d;
            irq_q   <= irq_d;
            eiN_q   <= ~en;
        end
    end

    assign EI_N   = eiN_q;
    assign irq_o  = irq_q;
    assign vec_o  = vec_q;
    assign idle_o = ~eoN_s;

`ifdef HC148_IRQ_CNT_EN
    logic             countEvt;
    logic [CNT_W-1:0] cnt_q [8];

    assign countEvt = en && ack_i && (state_q == PEND);

    // Per-vector service counters. Each one counts acknowledged requests
    // and saturates at all-ones.
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (countEvt && (cnt_q[vec_q] != {CNT_W{1'b1}})) begin
            cnt_q[vec_q] <= cnt_q[vec_q] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt_o = cnt_q[cnt_sel];
`else
    logic unused_cntSel;

    assign unused_cntSel = ^cnt_sel;
    assign cnt_o         = '0;
`endif

endmodule

// File: tb/tb_hc148_irq_latch.sv
// Directed testbench for hc148_irq_latch. Its expected values are worked
// out by hand from the encoder timing. The bench clocks the design on
// posedge, changes inputs 1 ns after an edge, and checks outputs at that
// same point.
module tb_hc148_irq_latch;

    localparam int CNT_W = 2;
`ifdef HC148_IRQ_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic             clk;
    logic             rst_N;
    logic             en;
    logic [2:0]       out_N;
    logic             GS_N;
    logic             EO_N;
    logic             EI_N;
    logic             irq_o;
    logic [2:0]       vec_o;
    logic             ack_i;
    logic             idle_o;
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_o;

    int checks;
    int failures;

    hc148_irq_latch #(.STABLE_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_N   (rst_N),
        .en      (en),
        .out_N   (out_N),
        .GS_N    (GS_N),
        .EO_N    (EO_N),
        .EI_N    (EI_N),
        .irq_o   (irq_o),
        .vec_o   (vec_o),
        .ack_i   (ack_i),
        .idle_o  (idle_o),
        .cnt_sel (cnt_sel),
        .cnt_o   (cnt_o)
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive the encoder-side request inputs.
    task automatic applyStimulus(input logic gs, input logic [2:0] code);
        GS_N  = gs;
        out_N = code;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Directed test sequence.
    initial begin
        checks   = 0;
        failures = 0;
        rst_N    = 1'b0;
        en       = 1'b0;
        ack_i    = 1'b0;
        cnt_sel  = 3'd0;
        EO_N     = 1'b1;
        applyStimulus(1'b1, 3'b111);
        tick(2);
        checkOutput("rst_irq", {7'd0, irq_o}, 8'd0);
        checkOutput("rst_vec", {5'd0, vec_o}, 8'd0);
        checkOutput("rst_ei", {7'd0, EI_N}, 8'd1);
        checkOutput("rst_idle", {7'd0, idle_o}, 8'd0);

        // Release reset and enable the encoder. EI_N follows en one edge
        // later, and idle_o follows EO_N two edges later.
        rst_N = 1'b1;
        en    = 1'b1;
        EO_N  = 1'b0;
        tick(1);
        checkOutput("en_ei", {7'd0, EI_N}, 8'd0);
        checkOutput("idle_sync1", {7'd0, idle_o}, 8'd0);
        tick(1);
        checkOutput("idle_sync2", {7'd0, idle_o}, 8'd1);

        // A stable request for vector 5 raises irq_o on edge 4.
        EO_N = 1'b1;
        applyStimulus(1'b0, 3'b010);
        tick(3);
        checkOutput("lat_e3", {7'd0, irq_o}, 8'd0);
        tick(1);
        checkOutput("lat_e4", {7'd0, irq_o}, 8'd1);
        checkOutput("lat_vec", {5'd0, vec_o}, 8'd5);
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        checkOutput("ack_clr", {7'd0, irq_o}, 8'd0);
        tick(20);
        checkOutput("held_norearm", {7'd0, irq_o}, 8'd0);
        applyStimulus(1'b1, 3'b111);
        tick(3);

        // A one-cycle glitch on GS_N never qualifies.
        applyStimulus(1'b0, 3'b110);
        tick(1);
        applyStimulus(1'b1, 3'b111);
        tick(3);
        checkOutput("glitch_a", {7'd0, irq_o}, 8'd0);
        tick(3);
        checkOutput("glitch_b", {7'd0, irq_o}, 8'd0);

        // A code change while in QUAL restarts qualification. The new code
        // reaches _s on edge 3, so irq_o rises two edges later, on edge 5.
        applyStimulus(1'b0, 3'b010);
        tick(1);
        applyStimulus(1'b0, 3'b000);
        tick(3);
        checkOutput("restart_e4", {7'd0, irq_o}, 8'd0);
        tick(1);
        checkOutput("restart_e5", {7'd0, irq_o}, 8'd1);
        checkOutput("restart_vec", {5'd0, vec_o}, 8'd7);
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        checkOutput("restart_ack", {7'd0, irq_o}, 8'd0);
        applyStimulus(1'b1, 3'b111);
        tick(3);

        // Dropping en in PEND wins over a simultaneous ack. The FSM goes to
        // IDLE, so the still-active request re-qualifies once en returns.
        applyStimulus(1'b0, 3'b101);
        tick(4);
        checkOutput("v2_irq", {7'd0, irq_o}, 8'd1);
        checkOutput("v2_vec", {5'd0, vec_o}, 8'd2);
        en    = 1'b0;
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        checkOutput("enlow_irq", {7'd0, irq_o}, 8'd0);
        checkOutput("enlow_ei", {7'd0, EI_N}, 8'd1);
        checkOutput("enlow_vec", {5'd0, vec_o}, 8'd2);
        cnt_sel = 3'd2;
        #1;
        checkOutput("enlow_cnt", {6'd0, cnt_o}, 8'd0);
        en = 1'b1;
        tick(2);
        checkOutput("reen_irq", {7'd0, irq_o}, 8'd1);

        // Five acknowledged services of vector 2. The 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            ack_i = 1'b1;
            tick(1);
            ack_i = 1'b0;
            checkOutput("loop_ack", {7'd0, irq_o}, 8'd0);
            applyStimulus(1'b1, 3'b111);
            tick(3);
            if (i < 4) begin
                applyStimulus(1'b0, 3'b101);
                tick(4);
                checkOutput("loop_irq", {7'd0, irq_o}, 8'd1);
            end
        end
        cnt_sel = 3'd2;
        #1;
        checkOutput("cnt_sat", {6'd0, cnt_o}, CntEn ? 8'd3 : 8'd0);
        cnt_sel = 3'd0;
        #1;
        checkOutput("cnt_zero", {6'd0, cnt_o}, 8'd0);

        // With ack_i held high, a new request is acknowledged on its first PEND cycle.
        ack_i = 1'b1;
        applyStimulus(1'b0, 3'b000);
        tick(4);
        checkOutput("heldack_irq", {7'd0, irq_o}, 8'd1);
        checkOutput("heldack_vec", {5'd0, vec_o}, 8'd7);
        tick(1);
        checkOutput("heldack_clr", {7'd0, irq_o}, 8'd0);
        ack_i = 1'b0;
        applyStimulus(1'b1, 3'b111);
        tick(3);

        // Asserting reset in PEND clears irq_o at once, without waiting for a clock edge.
        applyStimulus(1'b0, 3'b100);
        tick(4);
        checkOutput("pre_rst_irq", {7'd0, irq_o}, 8'd1);
        checkOutput("pre_rst_vec", {5'd0, vec_o}, 8'd3);
        #2;
        rst_N = 1'b0;
        #1;
        checkOutput("async_rst_irq", {7'd0, irq_o}, 8'd0);
        checkOutput("async_rst_vec", {5'd0, vec_o}, 8'd0);
        cnt_sel = 3'd2;
        #1;
        checkOutput("rst_cnt", {6'd0, cnt_o}, 8'd0);
        tick(1);
        rst_N = 1'b1;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
